// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: first-word-fall-through queue with overflow flag.
// Define UART_RX_PARITY_CHECK_EN to store and report a per-word parity error.
module uart_rx_fifo #(
  parameter int p_DATA_LEN   = 8,
  parameter int p_DEPTH      = 16,
  parameter int p_PARITY_ODD = 0
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [p_DATA_LEN:0]        i_data,
  input  logic                       i_dv,
  input  logic                       i_ready,
  input  logic                       i_clr,
  output logic                       o_valid,
  output logic [p_DATA_LEN-1:0]      o_data,
  output logic                       o_perr,
  output logic [$clog2(p_DEPTH):0]   o_count,
  output logic                       o_full,
  output logic                       o_overflow
);

  localparam int AW = $clog2(p_DEPTH);
  localparam int CW = AW + 1;
`ifdef UART_RX_PARITY_CHECK_EN
  localparam int EW = p_DATA_LEN + 1;
`else
  localparam int EW = p_DATA_LEN;
`endif

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [EW-1:0] mem_q [p_DEPTH];
  logic [EW-1:0] wr_entry;
  logic [EW-1:0] head;
  logic          empty, full;
  logic          do_wr, do_rd;

`ifdef UART_RX_PARITY_CHECK_EN
  assign wr_entry = {(^i_data) ^ (p_PARITY_ODD != 0),
                     i_data[p_DATA_LEN-1:0]};
`else
  logic unused_par;
  assign unused_par = i_data[p_DATA_LEN] ^ (p_PARITY_ODD != 0);
  assign wr_entry   = i_data[p_DATA_LEN-1:0];
`endif

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CW'(p_DEPTH));
    do_rd    = !empty && i_ready;
    // a pop in the same cycle frees the slot, so full + read still accepts
    do_wr    = i_dv && (!full || do_rd);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({do_wr, do_rd})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (i_clr) ovf_d = 1'b0;
    if (i_dv && full && !do_rd) ovf_d = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst_n && do_wr) mem_q[wr_ptr_q] <= wr_entry;
  end

  assign head       = mem_q[rd_ptr_q];
  assign o_valid    = !empty;
  assign o_data     = empty ? '0 : head[p_DATA_LEN-1:0];
`ifdef UART_RX_PARITY_CHECK_EN
  assign o_perr     = !empty && head[p_DATA_LEN];
`else
  assign o_perr     = 1'b0;
`endif
  assign o_count    = count_q;
  assign o_full     = full;
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: even-parity and odd-parity
// instances driven in lockstep from one stimulus stream.
module tb_uart_rx_fifo;

`ifdef UART_RX_PARITY_CHECK_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic [8:0] i_data = '0;
  logic       i_dv = 1'b0;
  logic       i_ready = 1'b0;
  logic       i_clr = 1'b0;

  logic       o_valid, o_perr, o_full, o_overflow;
  logic [7:0] o_data;
  logic [4:0] o_count;
  logic       od_valid, od_perr, od_full, od_overflow;
  logic [7:0] od_data;
  logic [4:0] od_count;

  int n_chk = 0;
  int n_fail = 0;
  logic [8:0] q[$];
  bit ovf = 1'b0;

  always #5 clk = ~clk;

  uart_rx_fifo dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_data(i_data),
    .i_dv(i_dv), .i_ready(i_ready), .i_clr(i_clr),
    .o_valid(o_valid), .o_data(o_data), .o_perr(o_perr),
    .o_count(o_count), .o_full(o_full), .o_overflow(o_overflow)
  );

  uart_rx_fifo #(.p_PARITY_ODD(1)) dut_odd (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_data(i_data),
    .i_dv(i_dv), .i_ready(i_ready), .i_clr(i_clr),
    .o_valid(od_valid), .o_data(od_data), .o_perr(od_perr),
    .o_count(od_count), .o_full(od_full),
    .o_overflow(od_overflow)
  );

  function automatic logic eperr(input logic [8:0] w, input bit odd);
    return ((^w) ^ odd) & PEN;
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input bit dv, input logic [8:0] d,
                      input bit rdy, input bit clr);
    bit fullm, rd, acc;
    i_dv = dv; i_data = d; i_ready = rdy; i_clr = clr;
    check("valid", o_valid, q.size() != 0);
    check("valid_odd", od_valid, q.size() != 0);
    if (q.size() != 0) begin
      check("data", o_data, q[0][7:0]);
      check("perr", o_perr, eperr(q[0], 1'b0));
      check("data_odd", od_data, q[0][7:0]);
      check("perr_odd", od_perr, eperr(q[0], 1'b1));
    end
    fullm = (q.size() == 16);
    rd    = (q.size() != 0) && rdy;
    acc   = dv && (!fullm || rd);
    if (rd) void'(q.pop_front());
    if (acc) q.push_back(d);
    if (clr) ovf = 1'b0;
    if (dv && fullm && !rd) ovf = 1'b1;
    @(posedge clk); #1;
    i_dv = 1'b0; i_ready = 1'b0; i_clr = 1'b0;
    check("count", o_count, q.size());
    check("count_odd", od_count, q.size());
    check("full", o_full, q.size() == 16);
    check("ovf", o_overflow, ovf);
    check("ovf_odd", od_overflow, ovf);
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0; i_dv = 1'b1; i_data = 9'h1FF;
    i_ready = 1'b1; i_clr = 1'b0;
    @(posedge clk); #1;
    i_rst_n = 1'b1; i_dv = 1'b0; i_ready = 1'b0;
    q.delete();
    ovf = 1'b0;
    check("rst_count", o_count, 0);
    check("rst_valid", o_valid, 0);
    check("rst_data", o_data, 0);
    check("rst_perr", o_perr, 0);
    check("rst_full", o_full, 0);
    check("rst_ovf", o_overflow, 0);
    check("rst_valid_odd", od_valid, 0);
  endtask

  initial begin
    do_reset();

    step(1'b1, 9'h1A5, 1'b0, 1'b0);
    check("r025_valid", o_valid, 1);
    check("r025_data", o_data, 8'hA5);
    check("r025_perr", o_perr, PEN);
    check("r025_count", o_count, 1);
    check("r025_perr_odd", od_perr, 0);
    step(1'b0, 9'h000, 1'b1, 1'b0);

    for (int i = 0; i < 16; i++)
      step(1'b1, {i[0], 8'(i)}, 1'b0, 1'b0);
    step(1'b1, 9'h055, 1'b0, 1'b0);
    check("r026_full", o_full, 1);
    check("r026_count", o_count, 16);
    check("r026_ovf", o_overflow, 1);
    check("r026_head", o_data, 8'h00);

    step(1'b0, 9'h000, 1'b0, 1'b1);
    check("clr_ovf", o_overflow, 0);
    step(1'b1, 9'h033, 1'b1, 1'b0);
    check("r027_count", o_count, 16);
    check("r027_ovf", o_overflow, 0);
    check("r027_head", o_data, 8'h01);

    step(1'b1, 9'h077, 1'b0, 1'b1);
    check("set_wins", o_overflow, 1);

    repeat (16) step(1'b0, 9'h000, 1'b1, 1'b0);
    check("drain_valid", o_valid, 0);
    step(1'b0, 9'h000, 1'b0, 1'b1);

    step(1'b1, 9'h011, 1'b0, 1'b0);
    step(1'b1, 9'h122, 1'b0, 1'b0);
    step(1'b1, 9'h044, 1'b0, 1'b0);
    repeat (10) step(1'b0, 9'h000, 1'b0, 1'b0);
    check("hold_data", o_data, 8'h11);
    repeat (3) step(1'b0, 9'h000, 1'b1, 1'b0);
    check("r028_valid", o_valid, 0);
    check("r028_count", o_count, 0);

    step(1'b1, 9'h0C3, 1'b1, 1'b0);
    check("r015_count", o_count, 1);
    step(1'b0, 9'h000, 1'b1, 1'b0);

    step(1'b1, 9'h0A5, 1'b0, 1'b0);
    check("r030_perr_odd_a", od_perr, PEN);
    step(1'b0, 9'h000, 1'b1, 1'b0);
    step(1'b1, 9'h1A5, 1'b0, 1'b0);
    check("r030_perr_odd_b", od_perr, 0);
    step(1'b0, 9'h000, 1'b1, 1'b0);

    for (int i = 0; i < 5; i++)
      step(1'b1, 9'(9'h060 + i), 1'b0, 1'b0);
    do_reset();
    step(1'b1, 9'h042, 1'b0, 1'b0);
    check("r029_head", o_data, 8'h42);
    check("r029_count", o_count, 1);

    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 2) != 0), 9'($urandom),
           1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 15) == 0));
    repeat (17) step(1'b0, 9'h000, 1'b1, 1'b0);
    check("final_valid", o_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
